iod_eye_train_ctrl: RTL and testbench
=====================================

# iod_eye_train_ctrl

Sequencer for one PolarFire IOD lane's receive delay line and eye monitor during clock or data training. It sweeps the input delay tap from 0 upward, clears and samples the EYE_MONITOR_EARLY/LATE flags at each tap, and records the longest contiguous error-free tap window. It then steps the delay line back to the window centre. It sits in the fabric between the training/alignment core and the IOD's DELAY_LINE_* and EYE_MONITOR_* pins, all on FAB_CLK.

## Interface
Parameters:
- NUM_TAPS, 128: delay-line taps scanned. TAP_W = $clog2(NUM_TAPS).
- SETTLE_CYCLES, 8: wait after any delay-line load or move before clearing flags. Must be ≥1.
- SAMPLE_CYCLES, 16: observation cycles per tap after the flag clear. Must be ≥1.
- MIN_WINDOW, 4: minimum passing taps for success.

Ports:
- FAB_CLK  in  1  fabric clock; all logic is on its rising edge.
- RESET_N  in  1  reset. Synchronous, active-low.
- TRAIN_START  in  1  single-cycle start request. Sampled only in IDLE.
- EYE_MONITOR_EARLY  in  1  IOD early flag, sticky until cleared.
- EYE_MONITOR_LATE  in  1  IOD late flag, sticky until cleared.
- DELAY_LINE_OUT_OF_RANGE  in  1  IOD delay-line saturation flag.
- EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle clear pulse to the IOD.
- DELAY_LINE_LOAD  out  1  one-cycle pulse; returns the delay line to tap 0.
- DELAY_LINE_MOVE  out  1  one-cycle step pulse.
- DELAY_LINE_DIRECTION  out  1  direction for the step: 1 = increment, 0 = decrement. Held valid in the same cycle as MOVE.
- TAP_POS  out  TAP_W  controller's model of the current tap.
- WIN_START  out  TAP_W  first tap of the chosen window.
- WIN_END  out  TAP_W  last tap of the chosen window.
- BUSY  out  1  high in every state except IDLE, DONE and FAIL.
- TRAIN_DONE  out  1  level; set on success, held until the next start.
- TRAIN_FAIL  out  1  level; set on failure, held until the next start.

## Operation
- Reset values: every output is 0, the FSM is in IDLE, and all counters are 0.
- FSM states: IDLE, LOAD, SETTLE, CLEAR, SAMPLE, EVAL, STEP, CENTER_SETTLE, CENTER_MOVE, DONE, FAIL.
- IDLE, DONE, FAIL on TRAIN_START go to LOAD. DONE, FAIL, WIN_START, WIN_END and the run registers are cleared at that point.
- LOAD pulses DELAY_LINE_LOAD, sets TAP_POS = 0, then goes to SETTLE.
- SETTLE counts SETTLE_CYCLES, then goes to CLEAR.
- CLEAR pulses EYE_MONITOR_CLEAR_FLAGS, then goes to SAMPLE.
- SAMPLE lasts SAMPLE_CYCLES cycles. err is set if EARLY | LATE is seen in any of them. The cycle that asserts the clear pulse is not sampled.
- EVAL classifies the tap: pass if !err.
  - Pass: run_len increments. If run_len was 0, run_start = TAP_POS.
  - Fail: run_len = 0.
  - If the updated run_len > best_len (strictly), the best window becomes run_start..TAP_POS. Ties keep the earlier window.
  - If TAP_POS == NUM_TAPS-1, or DELAY_LINE_OUT_OF_RANGE has been seen since the last move, the scan ends: go to CENTER_SETTLE. Otherwise go to STEP.
- STEP pulses MOVE with DIRECTION = 1, does TAP_POS++, then goes to SETTLE.
- Out-of-range handling: if OUT_OF_RANGE is seen during the SETTLE that follows a STEP, the current tap is treated as failed and the scan ends. TAP_POS stays at its value at the time of detection.
- Centre computation: centre = (WIN_START + WIN_END) >> 1, computed TAP_W+1 bits wide and truncated to TAP_W, rounding down.
- Failure: if best_len < MIN_WINDOW, go to FAIL. FAIL issues one LOAD pulse on entry and sets TAP_POS = 0.
- CENTER_MOVE: while TAP_POS > centre, pulse MOVE with DIRECTION = 0, decrement TAP_POS, then wait one CENTER_SETTLE cycle. When TAP_POS == centre, go to DONE.
- TRAIN_START while BUSY is ignored.
- Reset asserted mid-operation returns all outputs to reset values on the next edge. No further pulses are issued, and the IOD delay line is not reloaded.

## Timing
- MOVE, LOAD and CLEAR_FLAGS are each exactly one cycle, are registered, and are never asserted in the same cycle as each other.
- Consecutive MOVE pulses are at least 2 cycles apart.
- Per-tap scan cost = SETTLE_CYCLES + 1 (CLEAR) + SAMPLE_CYCLES + 1 (EVAL) + 1 (STEP).
- TRAIN_START to the first LOAD pulse: 1 cycle.
- Centring cost: 2 × (TAP_POS_end − centre) cycles.
- DONE/FAIL go high 1 cycle after the final transition. BUSY drops in that same cycle.

## Structure
- Shared package iod_train_pkg holds:
  - the state enum;
  - TAP_W as a localparam function of NUM_TAPS;
  - the direction constants DIR_INC = 1 and DIR_DEC = 0.
- One sub-module, iod_win_tracker: run/best bookkeeping driven by the EVAL strobe plus pass/fail, outputting WIN_START, WIN_END and best_len.
- The top level contains only the FSM and the counters.

## Test plan
- All taps pass, NUM_TAPS = 128 → WIN 0..127, exactly 127 up-steps followed by 64 down-steps, TAP_POS = 63, DONE.
- Taps 40..79 pass, all others set LATE → WIN 40..79, final TAP_POS = 59, DONE.
- Passing runs 10..19 and 50..69 → WIN 50..69, centre 59. Second variant with equal-length runs 10..29 and 50..69 → first window (10..29) kept, centre 19.
- Only taps 30..32 pass (MIN_WINDOW = 4) → FAIL = 1, one LOAD pulse, TAP_POS = 0, DONE = 0.
- OUT_OF_RANGE raised after the step to tap 100, taps 60..127 otherwise passing → tap 100 counted as fail, WIN 60..99, centre 79, DONE.
- RESET_N low during SAMPLE at tap 20 → next cycle all outputs 0 and IDLE. A TRAIN_START pulse during BUSY produces no restart, checked by the scan continuing unchanged.

Source files
------------

// File: rtl/iod_train_pkg.sv
// Shared types and helpers for the IOD eye-training sequencer.
package iod_train_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CLEAR,
    ST_SAMPLE,
    ST_EVAL,
    ST_STEP,
    ST_CENTER_SETTLE,
    ST_CENTER_MOVE,
    ST_DONE,
    ST_FAIL
  } train_state_e;

  localparam int DEF_NUM_TAPS = 128;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  function automatic int calc_tap_w(input int num_taps);
    return (num_taps > 1) ? $clog2(num_taps) : 1;
  endfunction

  // Counter only has to reach the larger of the two dwell lengths minus one.
  function automatic int calc_cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/iod_win_tracker.sv
// Tracks the current passing run and the longest passing window seen so far.
module iod_win_tracker
  import iod_train_pkg::*;
#(
  parameter int TAP_W = calc_tap_w(DEF_NUM_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_eval,
  input  logic             i_pass,
  input  logic [TAP_W-1:0] i_tap,
  output logic [TAP_W-1:0] o_win_start,
  output logic [TAP_W-1:0] o_win_end,
  output logic [TAP_W:0]   o_best_len
);

  logic [TAP_W:0]   r_run_len;
  logic [TAP_W:0]   r_best_len;
  logic [TAP_W-1:0] r_run_start;
  logic [TAP_W-1:0] r_best_start;
  logic [TAP_W-1:0] r_best_end;
  logic [TAP_W:0]   w_run_len_nxt;
  logic [TAP_W-1:0] w_run_start_nxt;

  always_comb begin
    w_run_len_nxt   = '0;
    w_run_start_nxt = r_run_start;
    if (i_pass) begin
      w_run_len_nxt = r_run_len + 1'b1;
      if (r_run_len == '0) begin
        w_run_start_nxt = i_tap;
      end
    end
  end

  // Strict compare keeps the earliest of equally long windows.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_run_len    <= '0;
      r_run_start  <= '0;
      r_best_len   <= '0;
      r_best_start <= '0;
      r_best_end   <= '0;
    end else if (i_eval) begin
      r_run_len   <= w_run_len_nxt;
      r_run_start <= w_run_start_nxt;
      if (w_run_len_nxt > r_best_len) begin
        r_best_len   <= w_run_len_nxt;
        r_best_start <= w_run_start_nxt;
        r_best_end   <= i_tap;
      end
    end
  end

  assign o_win_start = r_best_start;
  assign o_win_end   = r_best_end;
  assign o_best_len  = r_best_len;

endmodule

// File: rtl/iod_eye_train_ctrl.sv
// Sweeps the IOD receive delay line, scores each tap from the eye-monitor
// flags, then steps back to the centre of the longest error-free window.
module iod_eye_train_ctrl
  import iod_train_pkg::*;
#(
  parameter  int NUM_TAPS      = DEF_NUM_TAPS,
  parameter  int SETTLE_CYCLES = 8,
  parameter  int SAMPLE_CYCLES = 16,
  parameter  int MIN_WINDOW    = 4,
  localparam int TAP_W         = calc_tap_w(NUM_TAPS)
) (
  input  logic             FAB_CLK,
  input  logic             RESET_N,
  input  logic             TRAIN_START,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic [TAP_W-1:0] TAP_POS,
  output logic [TAP_W-1:0] WIN_START,
  output logic [TAP_W-1:0] WIN_END,
  output logic             BUSY,
  output logic             TRAIN_DONE,
  output logic             TRAIN_FAIL
);

  localparam int               CNT_W       = calc_cnt_w(SETTLE_CYCLES, SAMPLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(NUM_TAPS - 1);
  localparam logic [TAP_W:0]   MIN_LEN     = (TAP_W + 1)'(MIN_WINDOW);

  train_state_e     r_state;
  train_state_e     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [TAP_W-1:0] r_tap;
  logic             r_load;
  logic             r_clear;
  logic             r_move;
  logic             r_dir;
  logic             r_busy;
  logic             r_done;
  logic             r_fail;
  logic             r_err;
  logic             r_oor;
  logic             w_start;
  logic             w_eval;
  logic             w_fail_entry;
  logic [TAP_W-1:0] w_win_start;
  logic [TAP_W-1:0] w_win_end;
  logic [TAP_W:0]   w_best_len;
  logic [TAP_W:0]   w_centre_sum;
  logic [TAP_W-1:0] w_centre;

  assign w_start = ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_FAIL))
                   && TRAIN_START;
  assign w_eval  = (r_state == ST_EVAL);

  assign w_centre_sum = {1'b0, w_win_start} + {1'b0, w_win_end};
  assign w_centre     = TAP_W'(w_centre_sum >> 1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_FAIL: if (TRAIN_START) w_state_nxt = ST_LOAD;
      ST_LOAD:    w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        // A saturated delay line skips sampling; the tap is scored as failed.
        if (DELAY_LINE_OUT_OF_RANGE)   w_state_nxt = ST_EVAL;
        else if (r_cnt == SETTLE_LAST) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR:   w_state_nxt = ST_SAMPLE;
      ST_SAMPLE:  if (r_cnt == SAMPLE_LAST) w_state_nxt = ST_EVAL;
      ST_EVAL: begin
        if ((r_tap == TAP_LAST) || r_oor || DELAY_LINE_OUT_OF_RANGE) w_state_nxt = ST_CENTER_SETTLE;
        else                                                         w_state_nxt = ST_STEP;
      end
      ST_STEP:    w_state_nxt = ST_SETTLE;
      ST_CENTER_SETTLE: begin
        if (w_best_len < MIN_LEN) w_state_nxt = ST_FAIL;
        else if (r_tap > w_centre) w_state_nxt = ST_CENTER_MOVE;
        else                       w_state_nxt = ST_DONE;
      end
      ST_CENTER_MOVE: w_state_nxt = ST_CENTER_SETTLE;
      default:        w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = '0;
    if (((r_state == ST_SETTLE) || (r_state == ST_SAMPLE)) && (w_state_nxt == r_state)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  assign w_fail_entry = (w_state_nxt == ST_FAIL) && (r_state != ST_FAIL);

  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pulses and levels are registered from the next state so they line up
  // with the state they belong to.
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      r_cnt   <= '0;
      r_tap   <= '0;
      r_load  <= 1'b0;
      r_clear <= 1'b0;
      r_move  <= 1'b0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
      r_err   <= 1'b0;
      r_oor   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_load  <= (w_state_nxt == ST_LOAD) || w_fail_entry;
      r_clear <= (w_state_nxt == ST_CLEAR);
      r_move  <= (w_state_nxt == ST_STEP) || (w_state_nxt == ST_CENTER_MOVE);
      r_busy  <= !((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE) || (w_state_nxt == ST_FAIL));

      if (w_state_nxt == ST_STEP)             r_dir <= DIR_INC;
      else if (w_state_nxt == ST_CENTER_MOVE) r_dir <= DIR_DEC;

      if ((w_state_nxt == ST_LOAD) || w_fail_entry) r_tap <= '0;
      else if (w_state_nxt == ST_STEP)              r_tap <= r_tap + 1'b1;
      else if (w_state_nxt == ST_CENTER_MOVE)       r_tap <= r_tap - 1'b1;

      if (w_start)                     r_done <= 1'b0;
      else if (w_state_nxt == ST_DONE) r_done <= 1'b1;

      if (w_start)                     r_fail <= 1'b0;
      else if (w_state_nxt == ST_FAIL) r_fail <= 1'b1;

      case (r_state)
        ST_CLEAR:  r_err <= 1'b0;
        ST_SAMPLE: if (EYE_MONITOR_EARLY || EYE_MONITOR_LATE) r_err <= 1'b1;
        ST_SETTLE: if (DELAY_LINE_OUT_OF_RANGE) r_err <= 1'b1;
        default:   r_err <= r_err;
      endcase

      if ((w_state_nxt == ST_STEP) || (w_state_nxt == ST_LOAD)) begin
        r_oor <= 1'b0;
      end else if (((r_state == ST_SETTLE) || (r_state == ST_CLEAR) ||
                    (r_state == ST_SAMPLE) || (r_state == ST_EVAL)) && DELAY_LINE_OUT_OF_RANGE) begin
        r_oor <= 1'b1;
      end
    end
  end

  iod_win_tracker #(
    .TAP_W (TAP_W)
  ) u_win_tracker (
    .clk         (FAB_CLK),
    .rst_n       (RESET_N),
    .i_clear     (w_start),
    .i_eval      (w_eval),
    .i_pass      (!r_err),
    .i_tap       (r_tap),
    .o_win_start (w_win_start),
    .o_win_end   (w_win_end),
    .o_best_len  (w_best_len)
  );

  assign EYE_MONITOR_CLEAR_FLAGS = r_clear;
  assign DELAY_LINE_LOAD         = r_load;
  assign DELAY_LINE_MOVE         = r_move;
  assign DELAY_LINE_DIRECTION    = r_dir;
  assign TAP_POS                 = r_tap;
  assign WIN_START               = w_win_start;
  assign WIN_END                 = w_win_end;
  assign BUSY                    = r_busy;
  assign TRAIN_DONE              = r_done;
  assign TRAIN_FAIL              = r_fail;

endmodule

// File: tb/tb_iod_eye_train_ctrl.sv
// Bench for iod_eye_train_ctrl: behavioural IOD delay line / eye monitor model,
// table of training scenarios scored through a result queue, plus reset/busy-start sequence.
module tb_iod_eye_train_ctrl;

  localparam int NT     = 128;
  localparam int STL    = 8;
  localparam int SMP    = 16;
  localparam int MW     = 4;
  localparam int TW     = 7;
  localparam int UP_GAP = STL + SMP + 3;
  localparam int DN_GAP = 2;
  localparam int BUDGET = 6000;

  logic          FAB_CLK = 1'b0;
  logic          RESET_N;
  logic          TRAIN_START;
  logic          EYE_MONITOR_EARLY;
  logic          EYE_MONITOR_LATE;
  logic          DELAY_LINE_OUT_OF_RANGE;
  logic          EYE_MONITOR_CLEAR_FLAGS;
  logic          DELAY_LINE_LOAD;
  logic          DELAY_LINE_MOVE;
  logic          DELAY_LINE_DIRECTION;
  logic [TW-1:0] TAP_POS;
  logic [TW-1:0] WIN_START;
  logic [TW-1:0] WIN_END;
  logic          BUSY;
  logic          TRAIN_DONE;
  logic          TRAIN_FAIL;

  iod_eye_train_ctrl #(
    .NUM_TAPS      (NT),
    .SETTLE_CYCLES (STL),
    .SAMPLE_CYCLES (SMP),
    .MIN_WINDOW    (MW)
  ) dut (
    .FAB_CLK                 (FAB_CLK),
    .RESET_N                 (RESET_N),
    .TRAIN_START             (TRAIN_START),
    .EYE_MONITOR_EARLY       (EYE_MONITOR_EARLY),
    .EYE_MONITOR_LATE        (EYE_MONITOR_LATE),
    .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
    .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
    .TAP_POS                 (TAP_POS),
    .WIN_START               (WIN_START),
    .WIN_END                 (WIN_END),
    .BUSY                    (BUSY),
    .TRAIN_DONE              (TRAIN_DONE),
    .TRAIN_FAIL              (TRAIN_FAIL)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    string name;
    int    lo1, hi1, lo2, hi2;
    int    oor_from;
    int    done, fail;
    int    ws, we, tap;
    int    ups, downs, loads;
  } vec_t;

  vec_t vecs [6];
  vec_t sb_q [$];

  int checks = 0;
  int errors = 0;

  // IOD model state, updated mid-cycle from the DUT pulses
  int   pat_lo1 = -1, pat_hi1 = -2, pat_lo2 = -1, pat_hi2 = -2;
  int   oor_from = 1000;
  int   m_tap = 0;
  logic sticky_e = 1'b0, sticky_l = 1'b0;
  int   cyc = 0, ups = 0, downs = 0, loads = 0, clears = 0;
  int   proto_viol = 0, gap_viol = 0;
  int   mv_cyc = 0;
  logic mv_valid = 1'b0, mv_dir = 1'b0;
  logic p_load = 1'b0, p_move = 1'b0, p_clear = 1'b0;
  int   b_ups, b_downs, b_loads, b_clears;

  assign EYE_MONITOR_EARLY       = sticky_e;
  assign EYE_MONITOR_LATE        = sticky_l;
  assign DELAY_LINE_OUT_OF_RANGE = (m_tap >= oor_from);

  function automatic logic tap_pass(input int t);
    return ((t >= pat_lo1) && (t <= pat_hi1)) || ((t >= pat_lo2) && (t <= pat_hi2));
  endfunction

  always @(negedge FAB_CLK) begin
    cyc = cyc + 1;
    if ((int'(DELAY_LINE_LOAD) + int'(DELAY_LINE_MOVE) + int'(EYE_MONITOR_CLEAR_FLAGS)) > 1)
      proto_viol = proto_viol + 1;
    if ((DELAY_LINE_LOAD && p_load) || (DELAY_LINE_MOVE && p_move) || (EYE_MONITOR_CLEAR_FLAGS && p_clear))
      proto_viol = proto_viol + 1;
    p_load  = DELAY_LINE_LOAD;
    p_move  = DELAY_LINE_MOVE;
    p_clear = EYE_MONITOR_CLEAR_FLAGS;
    if (DELAY_LINE_LOAD === 1'b1) begin
      m_tap    = 0;
      loads    = loads + 1;
      mv_valid = 1'b0;
    end
    if (DELAY_LINE_MOVE === 1'b1) begin
      if (mv_valid && (DELAY_LINE_DIRECTION == mv_dir) &&
          ((cyc - mv_cyc) != (DELAY_LINE_DIRECTION ? UP_GAP : DN_GAP)))
        gap_viol = gap_viol + 1;
      mv_valid = 1'b1;
      mv_dir   = DELAY_LINE_DIRECTION;
      mv_cyc   = cyc;
      if (DELAY_LINE_DIRECTION) begin
        m_tap = m_tap + 1;
        ups   = ups + 1;
      end else begin
        m_tap = m_tap - 1;
        downs = downs + 1;
      end
    end
    if (EYE_MONITOR_CLEAR_FLAGS === 1'b1) begin
      sticky_e = 1'b0;
      sticky_l = 1'b0;
      clears   = clears + 1;
    end else if (!tap_pass(m_tap)) begin
      if (m_tap < 64) sticky_e = 1'b1;
      else            sticky_l = 1'b1;
    end
  end

  task automatic tick();
    @(negedge FAB_CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clear"}, EYE_MONITOR_CLEAR_FLAGS, 0);
    chk({tag, "_load"},  DELAY_LINE_LOAD, 0);
    chk({tag, "_move"},  DELAY_LINE_MOVE, 0);
    chk({tag, "_dir"},   DELAY_LINE_DIRECTION, 0);
    chk({tag, "_tap"},   TAP_POS, 0);
    chk({tag, "_ws"},    WIN_START, 0);
    chk({tag, "_we"},    WIN_END, 0);
    chk({tag, "_busy"},  BUSY, 0);
    chk({tag, "_done"},  TRAIN_DONE, 0);
    chk({tag, "_fail"},  TRAIN_FAIL, 0);
  endtask

  task automatic sb_check();
    vec_t e;
    chk("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.name, "_done"},  TRAIN_DONE, e.done);
      chk({e.name, "_fail"},  TRAIN_FAIL, e.fail);
      chk({e.name, "_busy"},  BUSY, 0);
      chk({e.name, "_ws"},    WIN_START, e.ws);
      chk({e.name, "_we"},    WIN_END, e.we);
      chk({e.name, "_tap"},   TAP_POS, e.tap);
      chk({e.name, "_mtap"},  m_tap, e.tap);
      chk({e.name, "_ups"},   ups - b_ups, e.ups);
      chk({e.name, "_downs"}, downs - b_downs, e.downs);
      chk({e.name, "_loads"}, loads - b_loads, e.loads);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    pat_lo1  = v.lo1;
    pat_hi1  = v.hi1;
    pat_lo2  = v.lo2;
    pat_hi2  = v.hi2;
    oor_from = v.oor_from;
    b_ups    = ups;
    b_downs  = downs;
    b_loads  = loads;
    sb_q.push_back(v);
    TRAIN_START = 1'b1;
    tick();
    TRAIN_START = 1'b0;
    chk({v.name, "_load_lat"}, DELAY_LINE_LOAD, 1);
    chk({v.name, "_busy_run"}, BUSY, 1);
    chk({v.name, "_lvl_clr"},  TRAIN_DONE | TRAIN_FAIL, 0);
    n = 0;
    while (!((TRAIN_DONE === 1'b1) || (TRAIN_FAIL === 1'b1)) && (n < BUDGET)) begin
      tick();
      n++;
    end
    chk({v.name, "_in_budget"}, (n < BUDGET), 1);
    sb_check();
    repeat (3) tick();
  endtask

  initial begin
    int n;
    vecs[0] = '{"all_pass",    0, 127, -1, -2, 1000, 1, 0,  0, 127, 63, 127,  64, 1};
    vecs[1] = '{"mid_40_79",  40,  79, -1, -2, 1000, 1, 0, 40,  79, 59, 127,  68, 1};
    vecs[2] = '{"two_runs",   10,  19, 50, 69, 1000, 1, 0, 50,  69, 59, 127,  68, 1};
    vecs[3] = '{"tie_runs",   10,  29, 50, 69, 1000, 1, 0, 10,  29, 19, 127, 108, 1};
    vecs[4] = '{"narrow",     30,  32, -1, -2, 1000, 0, 1, 30,  32,  0, 127,   0, 2};
    vecs[5] = '{"oor_100",    60, 127, -1, -2,  100, 1, 0, 60,  99, 79, 100,  21, 1};

    RESET_N     = 1'b0;
    TRAIN_START = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    RESET_N = 1'b1;
    tick();
    chk_all_zero("idle");

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end

    // Busy-start is ignored, then reset lands mid-sample at tap 20.
    pat_lo1  = 0;
    pat_hi1  = 127;
    pat_lo2  = -1;
    pat_hi2  = -2;
    oor_from = 1000;
    b_ups    = ups;
    b_loads  = loads;
    TRAIN_START = 1'b1;
    tick();
    TRAIN_START = 1'b0;
    n = 0;
    while ((TAP_POS != 5) && (n < BUDGET)) begin
      tick();
      n++;
    end
    chk("wait_tap5", (n < BUDGET), 1);
    TRAIN_START = 1'b1;
    tick();
    TRAIN_START = 1'b0;
    chk("busy_start_noload", DELAY_LINE_LOAD, 0);
    chk("busy_start_busy", BUSY, 1);
    n = 0;
    while (!((TAP_POS == 20) && (EYE_MONITOR_CLEAR_FLAGS === 1'b1)) && (n < BUDGET)) begin
      tick();
      n++;
    end
    chk("wait_tap20", (n < BUDGET), 1);
    chk("busy_start_loads", loads - b_loads, 1);
    chk("busy_start_ups", ups - b_ups, 20);
    repeat (3) tick();
    chk("pre_rst_busy", BUSY, 1);
    RESET_N = 1'b0;
    tick();
    chk_all_zero("midrst");
    RESET_N  = 1'b1;
    b_ups    = ups;
    b_downs  = downs;
    b_loads  = loads;
    b_clears = clears;
    repeat (20) tick();
    chk("post_rst_ups",    ups - b_ups, 0);
    chk("post_rst_downs",  downs - b_downs, 0);
    chk("post_rst_loads",  loads - b_loads, 0);
    chk("post_rst_clears", clears - b_clears, 0);
    chk_all_zero("post_rst");

    chk("pulse_protocol", proto_viol, 0);
    chk("move_spacing", gap_viol, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
